fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000: instruction word inserted into IF/ID on bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 stall  input  1  hold PC and IF/ID contents (hazard unit).
REQ-006 flush  input  1  replace IF/ID contents with a bubble.
REQ-007 branch_taken  input  1  redirect to branch_target.
REQ-008 branch_target  input  32  byte address of taken branch.
REQ-009 jump  input  1  redirect to jump_target.
REQ-010 jump_target  input  32  byte address of jump.
REQ-011 imem_addr  output  32  byte address to combinational instruction memory (word index = addr[15:2]).
REQ-012 imem_instr  input  32  instruction returned combinationally for imem_addr.
REQ-013 ifid_pc  output  32  PC of the instruction held in IF/ID.
REQ-014 ifid_pc_plus4  output  32  ifid_pc + 4.
REQ-015 ifid_instr  output  32  instruction held in IF/ID.
REQ-016 ifid_valid  output  1  IF/ID holds a real instruction.
REQ-017 misalign_err  output  1  sticky misaligned-redirect flag (present only with PC_ALIGN_CHECK_EN).

Function
REQ-018 The block SHALL drive imem_addr directly from the PC register, with no combinational path from the inputs.
REQ-019 Next-PC priority SHALL be: jump -> jump_target; else branch_taken -> branch_target; else stall -> PC held; else PC + 4.
REQ-020 A redirect SHALL override stall.
REQ-021 PC + 4 SHALL be computed modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-022 With no stall, flush or redirect, IF/ID SHALL capture {PC, PC+4, imem_instr, valid=1} on each edge, giving one-cycle latency from imem_addr to ifid_instr.
REQ-023 flush, jump or branch_taken SHALL load IF/ID with {pc=0, pc_plus4=0, instr=NOP_WORD, valid=0}, taking precedence over stall.
REQ-024 stall without flush or redirect SHALL hold all IF/ID outputs unchanged.
REQ-025 Simultaneous jump and branch_taken SHALL follow jump only.
REQ-026 Consecutive redirects SHALL each take effect on their own edge, with no lost or merged targets.

Reset
REQ-027 While rst is high at a rising edge, the block SHALL set PC=RESET_PC, ifid_pc=0, ifid_pc_plus4=0, ifid_instr=NOP_WORD, ifid_valid=0 and misalign_err=0, ignoring all other inputs.
REQ-028 On the first edge with rst low, IF/ID SHALL capture the instruction at RESET_PC with valid=1.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state.

Configuration
REQ-030 Macro PC_ALIGN_CHECK_EN defined: a redirect target with bits[1:0]!=0 SHALL set misalign_err; the PC SHALL load the target with bits[1:0] forced to 0; misalign_err SHALL stay set until reset.
REQ-031 Macro PC_ALIGN_CHECK_EN undefined: the misalign_err port SHALL be absent and targets SHALL be loaded with bits[1:0] forced to 0, with no flag.

Structure
REQ-032 A shared package SHALL hold the 32-bit address/word width constant, the NOP_WORD default, and the IF/ID bundle typedef {pc, pc_plus4, instr, valid}.
REQ-033 Next-PC selection SHALL be a sub-module, next_pc_sel: combinational, with inputs pc, stall, branch_taken, branch_target, jump and jump_target, and output next_pc.
REQ-034 The PC register and IF/ID register SHALL reside in fetch_stage.

Verification
REQ-035 rst high for 2 cycles, then low, with memory word0=0x2001_0005 -> imem_addr=0x0 after reset; next edge gives ifid_instr=0x2001_0005, ifid_pc=0, ifid_pc_plus4=4, valid=1.
REQ-036 Free-run 4 cycles -> imem_addr sequence 0x0, 0x4, 0x8, 0xC; ifid_pc lags by one cycle.
REQ-037 stall high for 3 cycles at PC=0x8 -> imem_addr stays 0x8 and IF/ID is unchanged; release -> 0xC on the next edge.
REQ-038 branch_taken=1 and jump=1 together, with branch_target=0x40 and jump_target=0x80, while stall=1 -> PC=0x80 and ifid_valid=0; next edge captures the instruction at 0x80.
REQ-039 PC=0xFFFF_FFFC with no stall -> next PC=0x0000_0000.
REQ-040 With PC_ALIGN_CHECK_EN defined, jump_target=0x102 -> PC=0x100 and misalign_err=1, which stays set until rst.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_DEFAULT = 32'h0000_0000;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t pc_plus4;
    word_t instr;
    logic  valid;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input word_t nop);
    ifid_t b;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.instr    = nop;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus plus IF/ID register outputs of the fetch stage.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  word_t imem_addr;
  word_t imem_instr;
  word_t ifid_pc;
  word_t ifid_pc_plus4;
  word_t ifid_instr;
  logic  ifid_valid;

  modport master (
    output imem_addr,
    input  imem_instr,
    output ifid_pc,
    output ifid_pc_plus4,
    output ifid_instr,
    output ifid_valid
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  ifid_pc,
    input  ifid_pc_plus4,
    input  ifid_instr,
    input  ifid_valid
  );

endinterface

// File: rtl/fetch_stage_next_pc_sel.sv
// Combinational next-PC selection: jump, then branch, then stall-hold, else PC+4.
module next_pc_sel
  import fetch_stage_pkg::*;
(
  input  word_t pc,
  input  logic  stall,
  input  logic  branch_taken,
  input  word_t branch_target,
  input  logic  jump,
  input  word_t jump_target,
  output word_t next_pc
);

  localparam word_t ALIGN_MASK = ~word_t'(32'h3);

  always_comb begin
    next_pc = pc + 32'd4;
    // Redirect targets are always word-aligned by dropping the low two bits.
    if (jump) begin
      next_pc = jump_target & ALIGN_MASK;
    end else if (branch_taken) begin
      next_pc = branch_target & ALIGN_MASK;
    end else if (stall) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, imem address drive and IF/ID pipeline register.
// Optional macro PC_ALIGN_CHECK_EN adds a sticky misaligned-redirect flag.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter word_t NOP_WORD = NOP_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          branch_taken,
  input  word_t         branch_target,
  input  logic          jump,
  input  word_t         jump_target,
  fetch_stage_if.master bus
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic          misalign_err
`endif
);

  word_t pc_q, pc_d;
  ifid_t ifid_q, ifid_d;
  logic  redirect;

  assign redirect = jump | branch_taken;

  next_pc_sel u_next_pc_sel (
    .pc            (pc_q),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .next_pc       (pc_d)
  );

  // A bubble wins over stall so a redirect never leaves a wrong-path instruction.
  always_comb begin
    ifid_d = ifid_q;
    if (flush || redirect) begin
      ifid_d = ifid_bubble(NOP_WORD);
    end else if (!stall) begin
      ifid_d.pc       = pc_q;
      ifid_d.pc_plus4 = pc_q + 32'd4;
      ifid_d.instr    = bus.imem_instr;
      ifid_d.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      ifid_q <= ifid_bubble(NOP_WORD);
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.ifid_pc       = ifid_q.pc;
  assign bus.ifid_pc_plus4 = ifid_q.pc_plus4;
  assign bus.ifid_instr    = ifid_q.instr;
  assign bus.ifid_valid    = ifid_q.valid;

`ifdef PC_ALIGN_CHECK_EN
  word_t eff_target;
  logic  err_q;

  assign eff_target = jump ? jump_target : branch_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (redirect && (eff_target[1:0] != 2'b00)) begin
      err_q <= 1'b1;
    end
  end

  assign misalign_err = err_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by random control traffic.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam word_t RST_PC = 32'h0000_0000;
  localparam word_t NOP    = 32'h0000_0000;

  typedef struct {
    word_t addr;
    word_t pc;
    word_t pc4;
    word_t instr;
    logic  valid;
    logic  err;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  stall = 1'b0;
  logic  flush = 1'b0;
  logic  branch_taken = 1'b0;
  word_t branch_target = '0;
  logic  jump = 1'b0;
  word_t jump_target = '0;
  logic  dut_err;

  word_t mem [0:16383];
  exp_t  sb [$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_txn = 0;

  // Reference state: the architectural PC and the instruction slot handed to decode.
  word_t m_pc = RST_PC;
  word_t m_spc = '0;
  word_t m_spc4 = '0;
  word_t m_sins = NOP;
  logic  m_sval = 1'b0;
  logic  m_err = 1'b0;

  fetch_stage_if bus ();

  assign bus.imem_instr = mem[bus.imem_addr[15:2]];

  fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_WORD (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .bus           (bus)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign_err  (dut_err)
`endif
  );

`ifndef PC_ALIGN_CHECK_EN
  assign dut_err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic cmp(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of control inputs and record what the fetch stage must show after the edge.
  task automatic step(input logic r, input logic s, input logic f, input logic b,
                      input word_t bt, input logic j, input word_t jt);
    word_t tgt;
    exp_t  e;
    @(negedge clk);
    rst = r; stall = s; flush = f;
    branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt;
    if (r) begin
      m_pc = RST_PC;
      m_spc = '0; m_spc4 = '0; m_sins = NOP; m_sval = 1'b0;
      m_err = 1'b0;
    end else begin
      tgt = j ? jt : bt;
      if (f || j || b) begin
        m_spc = '0; m_spc4 = '0; m_sins = NOP; m_sval = 1'b0;
      end else if (!s) begin
        m_spc = m_pc; m_spc4 = m_pc + 32'd4;
        m_sins = mem[m_pc[15:2]]; m_sval = 1'b1;
      end
      if (j || b) begin
        if (tgt % 4 != 0) m_err = 1'b1;
        m_pc = tgt - (tgt % 4);
      end else if (!s) begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.addr = m_pc; e.pc = m_spc; e.pc4 = m_spc4;
    e.instr = m_sins; e.valid = m_sval; e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // Monitor: every edge that has a pending expectation is checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_txn++;
        $display("txn %0d addr=%h ifid_pc=%h pc4=%h instr=%h valid=%b",
                 n_txn, bus.imem_addr, bus.ifid_pc, bus.ifid_pc_plus4, bus.ifid_instr, bus.ifid_valid);
        cmp("imem_addr", bus.imem_addr, e.addr);
        cmp("ifid_pc", bus.ifid_pc, e.pc);
        cmp("ifid_pc_plus4", bus.ifid_pc_plus4, e.pc4);
        cmp("ifid_instr", bus.ifid_instr, e.instr);
        cmp("ifid_valid", word_t'(bus.ifid_valid), word_t'(e.valid));
`ifdef PC_ALIGN_CHECK_EN
        cmp("misalign_err", word_t'(dut_err), word_t'(e.err));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[0] = 32'h2001_0005;

    // Reset for two cycles, then free-run through the stall window at PC=0x8.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(1);
    @(posedge clk); #2;
    cmp("first_instr", bus.ifid_instr, 32'h2001_0005);
    cmp("first_pc4", bus.ifid_pc_plus4, 32'h0000_0004);
    idle(1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    @(posedge clk); #2;
    cmp("stall_addr", bus.imem_addr, 32'h0000_0008);
    idle(2);

    // Jump and branch together under stall: jump wins.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
    idle(1);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
    idle(1);
    @(posedge clk); #2;
    cmp("wrap_addr", bus.imem_addr, 32'h0000_0000);
    idle(1);

    // Misaligned jump, back-to-back redirects, flush, then reset mid-stall/redirect.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h102);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h300);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h407, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h55, 1'b1, 32'h66);
    idle(2);

    for (int k = 0; k < 200; k++) begin
      word_t bt, jt;
      bt = $urandom;
      jt = $urandom;
      if ($urandom_range(0, 3) == 0) bt = 32'hFFFF_FFF0 | (bt & 32'hF);
      if ($urandom_range(0, 3) == 0) jt = jt & 32'h0000_FFFF;
      step($urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 12, bt,
           $urandom_range(0, 99) < 10, jt);
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
